// File: rtl/instr_enc.sv
// RV32I instruction encoder with a buffered valid/ready output stream.
// Optional macro IMM_RANGE_CHK_EN flags immediates that do not fit the format.
module instr_enc #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [6:0]       i_opcode,
  input  logic [4:0]       i_rd,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [2:0]       i_func3,
  input  logic [6:0]       i_func7,
  input  logic [31:0]      i_imm,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_instr,
  output logic             o_err,
  output logic [CNT_W-1:0] o_count
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_S   = 7'h23;
  localparam logic [6:0] OP_B   = 7'h63;
  localparam logic [6:0] OP_J   = 7'h6F;
  localparam logic [6:0] OP_JR  = 7'h67;
  localparam logic [6:0] OP_U   = 7'h37;
  localparam logic [6:0] OP_UPC = 7'h17;

`ifdef IMM_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic [31:0] word;
  logic        bad_op;
  logic        rng;
  logic        err;

  // a field is encodable when all bits above it replicate the sign
  function automatic logic all_eq(input logic [31:0] v, input int lo);
    logic z, o;
    z = 1'b1;
    o = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (k >= lo) begin
        z = z & ~v[k];
        o = o & v[k];
      end
    end
    return z | o;
  endfunction

  always_comb begin
    word   = '0;
    bad_op = 1'b0;
    rng    = 1'b0;
    case (i_opcode)
      OP_R: word = {i_func7, i_rs2, i_rs1,
                    i_func3, i_rd, i_opcode};
      OP_I, OP_LD, OP_JR: begin
        word = {i_imm[11:0], i_rs1,
                i_func3, i_rd, i_opcode};
        rng  = ~all_eq(i_imm, 11);
      end
      OP_S: begin
        word = {i_imm[11:5], i_rs2, i_rs1,
                i_func3, i_imm[4:0], i_opcode};
        rng  = ~all_eq(i_imm, 11);
      end
      OP_B: begin
        word = {i_imm[12], i_imm[10:5], i_rs2,
                i_rs1, i_func3, i_imm[4:1],
                i_imm[11], i_opcode};
        rng  = i_imm[0] | ~all_eq(i_imm, 12);
      end
      OP_J: begin
        word = {i_imm[20], i_imm[10:1], i_imm[11],
                i_imm[19:12], i_rd, i_opcode};
        rng  = i_imm[0] | ~all_eq(i_imm, 20);
      end
      OP_U, OP_UPC: begin
        word = {i_imm[31:12], i_rd, i_opcode};
        rng  = |i_imm[11:0];
      end
      default: begin
        word   = 32'h0000_0013;
        bad_op = 1'b1;
      end
    endcase
    err = bad_op | (CHK & rng);
  end

  logic [32:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          full, push, pop;

  assign full    = (occ == (AW+1)'(FIFO_DEPTH));
  assign o_ready = ~full;
  assign o_valid = (occ != '0);
  assign push    = i_valid & ~full;
  assign pop     = o_valid & i_ready;
  assign o_instr = o_valid ? mem[rd_ptr][31:0] : '0;
  assign o_err   = o_valid & mem[rd_ptr][32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++)
        mem[k] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      o_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {err, word};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        o_count <= o_count + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_enc.sv
// Bench for instr_enc: directed vectors plus random traffic
// checked against an arithmetic encoding model and a queue scoreboard.
module tb_instr_enc;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [6:0]  i_opcode;
  logic [4:0]  i_rd, i_rs1, i_rs2;
  logic [2:0]  i_func3;
  logic [6:0]  i_func7;
  logic [31:0] i_imm;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic        o_err;
  logic [15:0] o_count;

  int total = 0;
  int bad   = 0;
  logic [32:0] q[$];
  bit [15:0] exp_cnt;

  instr_enc #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_rd(i_rd),
    .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_func3(i_func3), .i_func7(i_func7),
    .i_imm(i_imm),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_instr(o_instr), .o_err(o_err),
    .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [32:0] obs,
                     input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] fld(bit [31:0] v, int lo, int n);
    return (v >> lo) & ((32'd1 << n) - 1);
  endfunction

  // reference encoder built from shifts and signed range arithmetic
  function automatic logic [32:0] model(
      bit [6:0] op, bit [4:0] rd, bit [4:0] rs1,
      bit [4:0] rs2, bit [2:0] f3, bit [6:0] f7,
      bit [31:0] imm);
    bit [31:0] w;
    bit oob;
    int si;
    si  = int'(imm);
    oob = 0;
    w   = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15);
    case (op)
      7'h33:
        w = w | (32'(rd) << 7) | (32'(rs2) << 20) | (32'(f7) << 25);
      7'h13, 7'h03, 7'h67: begin
        w = w | (32'(rd) << 7) | (fld(imm, 0, 12) << 20);
        oob = si < -2048 || si > 2047;
      end
      7'h23: begin
        w = w | (fld(imm, 0, 5) << 7) | (32'(rs2) << 20)
              | (fld(imm, 5, 7) << 25);
        oob = si < -2048 || si > 2047;
      end
      7'h63: begin
        w = w | (fld(imm, 11, 1) << 7) | (fld(imm, 1, 4) << 8)
              | (32'(rs2) << 20) | (fld(imm, 5, 6) << 25)
              | (fld(imm, 12, 1) << 31);
        oob = (si % 2 != 0) || si < -4096 || si > 4095;
      end
      7'h6F: begin
        w = 32'(op) | (32'(rd) << 7) | (fld(imm, 12, 8) << 12)
          | (fld(imm, 11, 1) << 20) | (fld(imm, 1, 10) << 21)
          | (fld(imm, 20, 1) << 31);
        oob = (si % 2 != 0) || si < -(1 << 20) || si >= (1 << 20);
      end
      7'h37, 7'h17: begin
        w = 32'(op) | (32'(rd) << 7) | (imm & 32'hFFFF_F000);
        oob = (imm % 4096) != 0;
      end
      default:
        return {1'b1, 32'h0000_0013};
    endcase
`ifdef IMM_RANGE_CHK_EN
    return {oob, w};
`else
    return {1'b0, w};
`endif
  endfunction

  // one clock: check outputs, advance model across the edge
  task automatic tick(output bit acc);
    bit psh, pp;
    psh = i_valid && o_ready;
    pp  = o_valid && i_ready;
    chk("ready", 33'(o_ready), 33'(q.size() < DEPTH));
    chk("valid", 33'(o_valid), 33'(q.size() != 0));
    if (q.size() == 0)
      chk("empty_instr", {o_err, o_instr}, 33'h0);
    else
      chk("head", {o_err, o_instr}, q[0]);
    @(posedge clk);
    if (pp) begin
      void'(q.pop_front());
      exp_cnt++;
    end
    if (psh)
      q.push_back(model(i_opcode, i_rd, i_rs1, i_rs2,
                        i_func3, i_func7, i_imm));
    acc = psh;
    #1;
    chk("count", 33'(o_count), 33'(exp_cnt));
    @(negedge clk);
  endtask

  task automatic set_req(bit [6:0] op, bit [4:0] rd,
                         bit [4:0] rs1, bit [4:0] rs2,
                         bit [2:0] f3, bit [6:0] f7,
                         bit [31:0] imm);
    i_opcode = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2;
    i_func3 = f3; i_func7 = f7; i_imm = imm;
  endtask

  task automatic send(bit [6:0] op, bit [4:0] rd,
                      bit [4:0] rs1, bit [4:0] rs2,
                      bit [2:0] f3, bit [6:0] f7,
                      bit [31:0] imm);
    bit acc;
    int n;
    set_req(op, rd, rs1, rs2, f3, f7, imm);
    i_valid = 1'b1;
    acc = 0;
    n = 0;
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    if (!acc) chk("send_timeout", 33'(acc), 33'h1);
    i_valid = 1'b0;
  endtask

  // directed single request from empty with i_ready high
  task automatic directed(string tag, bit [6:0] op,
                          bit [4:0] rd, bit [4:0] rs1,
                          bit [4:0] rs2, bit [2:0] f3,
                          bit [31:0] imm, bit [31:0] w,
                          bit e);
    bit acc;
    i_ready = 1'b1;
    send(op, rd, rs1, rs2, f3, 7'h0, imm);
    chk(tag, {o_err, o_instr}, {e, w});
    tick(acc);
  endtask

  initial begin
    bit acc;
    bit e_rng;
    int n;
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    set_req(7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0);
    exp_cnt = '0;
    #12;
    chk("rst_valid", 33'(o_valid), 33'h0);
    chk("rst_ready", 33'(o_ready), 33'h1);
    chk("rst_count", 33'(o_count), 33'h0);
    chk("rst_instr", {o_err, o_instr}, 33'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // two entries buffered, then reset mid-stream
    send(7'h13, 5'd3, 5'd4, 5'd0, 3'd0, 7'h0, 32'd5);
    send(7'h33, 5'd6, 5'd7, 5'd8, 3'd1, 7'h20, 32'd0);
    chk("two_buf_valid", 33'(o_valid), 33'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 33'(o_valid), 33'h0);
    chk("midrst_ready", 33'(o_ready), 33'h1);
    chk("midrst_count", 33'(o_count), 33'h0);
    q.delete();
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    directed("addi", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0,
             32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    directed("beq", 7'h63, 5'd0, 5'd1, 5'd2, 3'd0,
             32'd8, 32'h0020_8463, 1'b0);
    directed("jal", 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0,
             32'h800, 32'h0010_00EF, 1'b0);
    directed("lui", 7'h37, 5'd5, 5'd0, 5'd0, 3'd0,
             32'h1234_5000, 32'h1234_52B7, 1'b0);
    directed("badop", 7'h7F, 5'd9, 5'd9, 5'd9, 3'd7,
             32'h0, 32'h0000_0013, 1'b1);

`ifdef IMM_RANGE_CHK_EN
    e_rng = 1'b1;
`else
    e_rng = 1'b0;
`endif
    directed("b_odd", 7'h63, 5'd0, 5'd0, 5'd0, 3'd0,
             32'd7, 32'h0000_0363, e_rng);
    directed("addi_2048", 7'h13, 5'd0, 5'd0, 5'd0, 3'd0,
             32'd2048, 32'h8000_0013, e_rng);

    // backpressure: three requests, only two fit
    i_ready = 1'b0;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      set_req(7'h33, 5'(k + 1), 5'(k + 2), 5'(k + 3),
              3'(k), 7'(k), 32'h0);
      i_valid = 1'b1;
      tick(acc);
      if (acc) n++;
    end
    chk("bp_accepted", 33'(n), 33'd2);
    chk("bp_ready_low", 33'(o_ready), 33'h0);
    exp_cnt = o_count + 16'd0 == exp_cnt ? exp_cnt : exp_cnt;
    i_ready = 1'b1;
    n = 0;
    while (!acc && n < 10) begin
      tick(acc);
      n++;
    end
    chk("bp_third_in", 33'(acc), 33'h1);
    i_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      tick(acc);
      n++;
    end
    chk("bp_drained", 33'(q.size()), 33'h0);
    chk("bp_count", 33'(o_count), 33'd10);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      bit [6:0] ops [10];
      bit [31:0] imm;
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
              7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = 32'($urandom_range(0, 1 << 21)) - 32'(1 << 20);
        default: imm = $urandom & 32'hFFFF_F000;
      endcase
      set_req(ops[$urandom_range(0, 9)], 5'($urandom),
              5'($urandom), 5'($urandom), 3'($urandom),
              7'($urandom), imm);
      if ($urandom_range(0, 15) == 0) i_opcode = 7'($urandom);
      i_valid = 1'($urandom);
      i_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
    end

    i_valid = 1'b0;
    i_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      tick(acc);
      n++;
    end
    chk("final_drain", 33'(q.size()), 33'h0);
    tick(acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
